// File: rtl/alu_pkg.sv
// Shared ALU result-path definitions: output channel count, select/count widths,
// channel index constants and the per-slot state encoding.
package alu_pkg;

  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned CNT_W   = 4;

  localparam logic [SEL_W-1:0] CH_0 = SEL_W'(0);
  localparam logic [SEL_W-1:0] CH_1 = SEL_W'(1);
  localparam logic [SEL_W-1:0] CH_2 = SEL_W'(2);
  localparam logic [SEL_W-1:0] CH_3 = SEL_W'(3);
  localparam logic [SEL_W-1:0] CH_4 = SEL_W'(4);
  localparam logic [SEL_W-1:0] CH_5 = SEL_W'(5);
  localparam logic [SEL_W-1:0] CH_6 = SEL_W'(6);
  localparam logic [SEL_W-1:0] CH_7 = SEL_W'(7);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Number of set bits in a channel vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_OUT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/result_slot.sv
// One-entry holding register for a single output channel with EMPTY/FULL state.
// A load in the same cycle as a drain keeps the slot FULL with the new word.
module result_slot
  import alu_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid
);

  slot_state_t state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (load) state_next = SLOT_FULL;
      SLOT_FULL:  if (ready && !load) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  // Data holds its last value after a drain; only a load replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/result_demux1to8.sv
// ALU result distributor: routes one tagged word per cycle into one of eight
// single-entry output channels, each with its own valid/ready handshake.
module result_demux1to8
  import alu_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_OUT*W-1:0] out_data,
  output logic [NUM_OUT-1:0]   out_valid,
  input  logic [NUM_OUT-1:0]   out_ready,
  output logic [CNT_W-1:0]     pending
);

  logic [NUM_OUT-1:0] valid;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] drain;
  logic               accept;
  logic [CNT_W-1:0]   pending_next;

  // Ready passes straight through from the selected consumer when its slot is full.
  assign in_ready = rst_n && (!valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;
  assign load     = accept ? (NUM_OUT'(1) << in_sel) : '0;
  assign drain    = valid & out_ready;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    result_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .data      (out_data[k*W +: W]),
      .valid     (valid[k])
    );
  end

  assign out_valid = valid;

  // Refilled drains cancel out; only an accept into an empty slot adds one.
  assign pending_next = pending
                      + CNT_W'(accept && !valid[in_sel])
                      - popcount(drain & ~load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_result_demux1to8.sv
// Scoreboard bench for result_demux1to8: directed routes, back-pressure, streaming,
// fill/partial drain and asynchronous mid-operation reset.
module tb_result_demux1to8;
  import alu_pkg::*;

  localparam int unsigned W = 64;

  logic                 clk;
  logic                 rst_n;
  logic [W-1:0]         in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_OUT*W-1:0] out_data;
  logic [NUM_OUT-1:0]   out_valid;
  logic [NUM_OUT-1:0]   out_ready;
  logic [CNT_W-1:0]     pending;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [NUM_OUT][$];

  result_demux1to8 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ch_data(input int k);
    return out_data[k*W +: W];
  endfunction

  // Monitor: every drain handshake pops the channel's expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL drain_ch%0d: got %h expected no word", k, ch_data(k));
          end else begin
            logic [W-1:0] e;
            e = exp_q[k].pop_front();
            if (ch_data(k) !== e) begin
              errors++;
              $display("FAIL drain_ch%0d: got %h expected %h", k, ch_data(k), e);
            end
          end
        end
      end
    end
  end

  // Present a word from the next cycle on; returns once it is accepted (bounded wait).
  task automatic send(input logic [SEL_W-1:0] sel, input logic [W-1:0] d, output int stalls);
    bit done;
    stalls = 0;
    done   = 1'b0;
    @(posedge clk) #1;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q[sel].push_back(d);
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles (sel %0d)", sel);
    end
  endtask

  task automatic idle();
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  int st;
  int total_stalls;
  int leftover;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = CH_0;
    in_data   = 64'hFFFF_0000_FFFF_0000;
    out_ready = '0;

    // Reset held with a word offered
    repeat (2) @(negedge clk);
    chk("reset_in_ready", W'(in_ready), W'(0));
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_pending", W'(pending), W'(0));
    chk("reset_out_data", out_data[W-1:0], W'(0));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid", W'(out_valid), W'(0));
    chk("post_reset_pending", W'(pending), W'(0));

    // Single route to channel 5
    send(CH_5, 64'hDEAD_BEEF_0000_0005, st);
    chk("route_stalls", W'(st), W'(0));
    idle();
    @(negedge clk);
    chk("route_out_valid", W'(out_valid), W'(8'h20));
    chk("route_data5", ch_data(5), 64'hDEAD_BEEF_0000_0005);
    chk("route_pending", W'(pending), W'(1));

    // Back-pressure on channel 5, then a different channel gets through
    @(posedge clk) #1;
    in_valid = 1'b1;
    in_sel   = CH_5;
    in_data  = 64'h5555_0000_0000_0002;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    chk("bp_data5_held", ch_data(5), 64'hDEAD_BEEF_0000_0005);
    chk("bp_pending_held", W'(pending), W'(1));
    send(CH_2, 64'h2222_0000_0000_0002, st);
    chk("bp_sel2_stalls", W'(st), W'(0));
    idle();
    @(negedge clk);
    chk("bp_pending", W'(pending), W'(2));
    chk("bp_out_valid", W'(out_valid), W'(8'h24));
    chk("bp_data2", ch_data(2), 64'h2222_0000_0000_0002);

    // Drain both; data stays after the drain
    @(posedge clk) #1;
    out_ready = 8'hFF;
    repeat (2) @(negedge clk);
    chk("drain_pending", W'(pending), W'(0));
    chk("drain_out_valid", W'(out_valid), W'(0));
    chk("drain_data5_kept", ch_data(5), 64'hDEAD_BEEF_0000_0005);

    // Streaming 1..16 into channel 3 with consumers always ready
    total_stalls = 0;
    for (int i = 1; i <= 16; i++) begin
      send(CH_3, W'(i), st);
      total_stalls += st;
      if (i > 1) chk("stream_no_bubble", W'(out_valid[3]), W'(1));
      if (i > 1) chk("stream_pending", W'(pending), W'(1));
    end
    chk("stream_stalls", W'(total_stalls), W'(0));
    idle();
    repeat (2) @(negedge clk);
    chk("stream_end_pending", W'(pending), W'(0));

    // Fill every channel, then drain channels 0 and 7
    @(posedge clk) #1;
    out_ready = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      send(SEL_W'(k), 64'h0000_1000_0000_0000 + W'(k), st);
    end
    idle();
    @(negedge clk);
    chk("fill_pending", W'(pending), W'(8));
    chk("fill_out_valid", W'(out_valid), W'(8'hFF));
    chk("fill_in_ready", W'(in_ready), W'(0));
    @(posedge clk) #1;
    out_ready = 8'h81;
    @(negedge clk);
    @(negedge clk);
    chk("partial_pending", W'(pending), W'(6));
    chk("partial_out_valid", W'(out_valid), W'(8'h7E));

    // Empty everything, load three slots, then reset between edges
    @(posedge clk) #1;
    out_ready = 8'hFF;
    repeat (2) @(negedge clk);
    chk("empty_pending", W'(pending), W'(0));
    @(posedge clk) #1;
    out_ready = '0;
    send(CH_1, 64'h0000_0000_0000_00A1, st);
    send(CH_4, 64'h0000_0000_0000_00A4, st);
    send(CH_6, 64'h0000_0000_0000_00A6, st);
    idle();
    @(negedge clk);
    chk("pre_reset_pending", W'(pending), W'(3));
    chk("pre_reset_out_valid", W'(out_valid), W'(8'h52));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", W'(out_valid), W'(0));
    chk("async_reset_pending", W'(pending), W'(0));
    chk("async_reset_in_ready", W'(in_ready), W'(0));
    chk("async_reset_data4", ch_data(4), W'(0));
    for (int k = 0; k < NUM_OUT; k++) exp_q[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_out_valid", W'(out_valid), W'(0));

    // Recovery: one more route with consumers ready
    @(posedge clk) #1;
    out_ready = 8'hFF;
    send(CH_7, 64'h7777_7777_7777_7777, st);
    idle();
    repeat (3) @(negedge clk);
    chk("final_pending", W'(pending), W'(0));
    leftover = 0;
    for (int k = 0; k < NUM_OUT; k++) leftover += exp_q[k].size();
    chk("scoreboard_empty", W'(leftover), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
